// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and bit-period computation,
// common to both UART directions.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRxData,
    StParity,
    StStop,
    StCleanup
  } uart_state_e;

  localparam int unsigned MinClkPerBit = 4;

  function automatic int unsigned clk_per_bit(input int unsigned clock_rate,
                                              input int unsigned baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (arst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH data bits LSB first, optional even parity, one stop bit.
// Define UART_RX_PARITY_EN to compile in the parity bit and parity_err check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 1_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  d,
  output logic                  dv,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  active,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam int unsigned CLK_PER_BIT = clk_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int unsigned MID         = CLK_PER_BIT / 2;
  localparam int unsigned CntW        = $clog2(CLK_PER_BIT);
  localparam int unsigned BitW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntMidLast = CntW'(MID - 1);
  localparam logic [CntW-1:0] CntBitLast = CntW'(CLK_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast    = BitW'(DATA_WIDTH - 1);

  if (CLK_PER_BIT < MinClkPerBit) begin : gen_rate_check
    $error("uart_rx: CLOCK_RATE/BAUD_RATE must be at least 4");
  end

  logic ds;

  uart_sync u_sync (
    .clk  (clk),
    .arst (arst),
    .d    (d),
    .q    (ds)
  );

  uart_state_e           state_q, state_d;
  logic [CntW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  active_q, active_d;
  logic                  dv_q, dv_d;
  logic                  frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    active_d    = active_q;
    dv_d        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!ds) begin
          state_d  = StStart;
          active_d = 1'b1;
        end
      end
      StStart: begin
        if (clk_cnt_q == CntMidLast) begin
          clk_cnt_d = '0;
          if (!ds) begin
            state_d = StRxData;
          end else begin
            // Start bit did not survive to mid-bit: treat as a glitch.
            state_d  = StIdle;
            active_d = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StRxData: begin
        if (clk_cnt_q == CntBitLast) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = ds;
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (clk_cnt_q == CntBitLast) begin
          clk_cnt_d = '0;
          par_bad_d = (^shift_q) ^ ds;
          state_d   = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (clk_cnt_q == CntBitLast) begin
          clk_cnt_d = '0;
          state_d   = StCleanup;
          if (ds) begin
            data_d = shift_q;
            dv_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StCleanup: begin
        active_d = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        active_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      active_q    <= 1'b0;
      dv_q        <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      active_q    <= active_d;
      dv_q        <= dv_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dv        = dv_q;
  assign data      = data_q;
  assign active    = active_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of expected words/frame errors checked on each pulse.
module tb_uart_rx;

  localparam int unsigned CPB = 8;

  logic       clk = 1'b0;
  logic       arst;
  logic       d;
  logic       dv;
  logic [7:0] data;
  logic       active;
  logic       frame_err;
  logic       parity_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       is_ferr;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  uart_rx #(
    .CLOCK_RATE (1_000_000),
    .BAUD_RATE  (115_200),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .d          (d),
    .dv         (dv),
    .data       (data),
    .active     (active),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    d = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`endif
    send_bit(stop_bit);
    d = 1'b1;
  endtask

  task automatic push_dv(input logic [7:0] b, input logic perr);
    exp_t e;
    e.is_ferr = 1'b0;
    e.data    = b;
    e.perr    = perr;
    sb.push_back(e);
  endtask

  task automatic push_ferr();
    exp_t e;
    e.is_ferr = 1'b1;
    e.data    = 8'h00;
    e.perr    = 1'b0;
    sb.push_back(e);
  endtask

  // Bounded wait for the receiver to drop active, then leave an idle gap.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (active && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, active}, 32'd0);
    repeat (16) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dv"}, {31'd0, dv}, 32'd0);
    chk({tag, "_data"}, {24'd0, data}, 32'd0);
    chk({tag, "_active"}, {31'd0, active}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected entry.
  logic dv_p = 1'b0;
  logic fe_p = 1'b0;
  logic pe_p = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (dv || frame_err) begin
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        if (dv) begin
          chk("dv_kind", {31'd0, mon_e.is_ferr}, 32'd0);
          chk("dv_data", {24'd0, data}, {24'd0, mon_e.data});
          chk("dv_perr", {31'd0, parity_err}, {31'd0, mon_e.perr});
          chk("dv_no_fe", {31'd0, frame_err}, 32'd0);
        end else begin
          chk("fe_kind", {31'd0, mon_e.is_ferr}, 32'd1);
          chk("fe_no_perr", {31'd0, parity_err}, 32'd0);
        end
      end
    end else if (parity_err) begin
      chk("perr_alone", {31'd0, parity_err}, 32'd0);
    end
    if (dv_p) chk("dv_width", {31'd0, dv}, 32'd0);
    if (fe_p) chk("fe_width", {31'd0, frame_err}, 32'd0);
    if (pe_p) chk("pe_width", {31'd0, parity_err}, 32'd0);
    dv_p = dv;
    fe_p = frame_err;
    pe_p = parity_err;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    arst = 1'b1;
    d    = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    arst = 1'b0;
    repeat (4) @(negedge clk);

    // Good frame 0xA5.
    push_dv(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    wait_idle("a5_idle");
    chk("a5_data", {24'd0, data}, 32'h0000_00A5);

    // Two-cycle glitch: brief active pulse, no output pulse.
    d = 1'b0;
    repeat (2) @(negedge clk);
    d = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (active) n++;
    end
    chk("glitch_seen", {31'd0, n != 0}, 32'd1);
    chk("glitch_width", {31'd0, n <= 7}, 32'd1);
    chk("glitch_idle", {31'd0, active}, 32'd0);

    // Stop bit low: frame error, data keeps 0xA5.
    push_ferr();
    send_frame(8'h3C, 1'b0, ^8'h3C);
    wait_idle("ferr_idle");
    chk("ferr_data_kept", {24'd0, data}, 32'h0000_00A5);

    // Back-to-back frames with no idle gap.
    push_dv(8'h01, 1'b0);
    push_dv(8'hFE, 1'b0);
    send_frame(8'h01, 1'b1, ^8'h01);
    send_frame(8'hFE, 1'b1, ^8'hFE);
    wait_idle("b2b_idle");
    chk("b2b_data", {24'd0, data}, 32'h0000_00FE);

    // Reset in the middle of 0x55's data bits.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    arst = 1'b1;
    d    = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    arst = 1'b0;
    repeat (20) @(negedge clk);
    push_dv(8'h99, 1'b0);
    send_frame(8'h99, 1'b1, ^8'h99);
    wait_idle("r99_idle");
    chk("r99_data", {24'd0, data}, 32'h0000_0099);

`ifdef UART_RX_PARITY_EN
    push_dv(8'h07, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_idle("par_ok_idle");
    push_dv(8'h07, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_idle("par_bad_idle");
    chk("par_data", {24'd0, data}, 32'h0000_0007);
`endif

    repeat (20) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 1_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning serial bit rate.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port arst  input  1  reset, synchronous to clk, active-high.
REQ-006 SHALL have port d  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port dv  output  1  one-cycle pulse: data holds a valid received word.
REQ-008 SHALL have port data  output  DATA_WIDTH  last received word, LSB first on the line.
REQ-009 SHALL have port active  output  1  high from start-bit detect until return to IDLE.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch.

Function
REQ-012 SHALL define CLK_PER_BIT = CLOCK_RATE/BAUD_RATE (integer division) and MID = CLK_PER_BIT/2; CLK_PER_BIT < 4 SHALL be a compile-time error.
REQ-013 SHALL pass d through a 2-flop synchronizer; all decisions SHALL use the synchronized value ds.
REQ-014 SHALL implement states IDLE, START, RX_DATA, PARITY, STOP, CLEANUP.
REQ-015 IDLE: clk_cnt=0, bit_cnt=0; ds==0 -> START, active<=1.
REQ-016 START: count to clk_cnt==MID-1; then ds==0 -> RX_DATA with clk_cnt=0; ds==1 (glitch) -> IDLE, active<=0, no pulse.
REQ-017 RX_DATA: at clk_cnt==CLK_PER_BIT-1, shift register bit[bit_cnt]<=ds and clk_cnt<=0; after bit DATA_WIDTH-1 -> PARITY if enabled, else STOP.
REQ-018 PARITY: sample at clk_cnt==CLK_PER_BIT-1; even parity over the data bits plus the parity bit; result held for STOP.
REQ-019 STOP: sample at clk_cnt==CLK_PER_BIT-1; next cycle -> CLEANUP.
REQ-020 Stop high: data<=shift register and dv=1 for exactly the next cycle; a parity mismatch additionally pulses parity_err in that same cycle.
REQ-021 Stop low: frame_err=1 for exactly the next cycle, dv=0, data unchanged, parity_err=0.
REQ-022 CLEANUP: one cycle, active<=0 -> IDLE; a start bit arriving then SHALL be detected in IDLE (back-to-back frames lose no frame).
REQ-023 data SHALL hold its value between dv pulses; dv, frame_err and parity_err SHALL never be high for more than one cycle.
REQ-024 Latency: dv rises 1 cycle after the mid-stop sample cycle, i.e. ~(DATA_WIDTH+1.5)*CLK_PER_BIT+3 cycles after d falls (plus CLK_PER_BIT with parity).

Reset
REQ-025 arst high at a clock edge SHALL force state IDLE, synchronizer flops 1, clk_cnt/bit_cnt 0, data 0, dv/active/frame_err/parity_err 0.
REQ-026 Reset mid-frame SHALL abandon the frame without any pulse; reception SHALL resume at the next falling edge after release.

Configuration
REQ-027 Macro UART_RX_PARITY_EN SHALL compile in the PARITY state and parity check (frame = start, DATA_WIDTH data, even parity, stop).
REQ-028 Without UART_RX_PARITY_EN, PARITY SHALL be unreachable/absent, RX_DATA SHALL go directly to STOP, and parity_err SHALL be tied 0.

Structure
REQ-029 State encodings and the CLK_PER_BIT computation SHALL reside in shared package uart_pkg, used by both UART directions.
REQ-030 Synchronizer SHALL be sub-module uart_sync (2 flops, reset value 1); everything else in uart_rx.

Verification (CLOCK_RATE=1_000_000, BAUD_RATE=115_200 -> CLK_PER_BIT=8, MID=4, DATA_WIDTH=8)
REQ-031 Frame 0xA5, valid stop -> one dv pulse, data==8'hA5, frame_err=0, active low again after CLEANUP.
REQ-032 d low for 2 cycles then high -> state returns to IDLE, no dv/frame_err, active pulse <= MID+3 cycles.
REQ-033 Frame 0x3C with stop bit low -> frame_err pulse, no dv, data keeps previous 8'hA5.
REQ-034 Frames 0x01 then 0xFE back-to-back (no idle gap) -> two dv pulses, data 8'h01 then 8'hFE.
REQ-035 arst asserted mid-data of 0x55 -> all outputs 0 next cycle, no pulse; following 0x99 received correctly.
REQ-036 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> dv, parity_err=0; with parity bit 0 -> dv and parity_err same cycle.
